// File: rtl/pipelined_instruction_decoder.sv
// RV32I decode stage for the barrel-threaded core.
// An instruction is decoded combinationally on entry and stored in decoded
// form. Storage is an output register (OR) that drives every output, plus a
// one-entry skid register (SK) that absorbs a single beat of backpressure.
// A per-thread flush drops stored and incoming entries of a redirected thread.
module pipelined_instruction_decoder #(
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 16,
    parameter int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic [TID_W-1:0] i_tid,
    input  logic             i_flush,
    input  logic [TID_W-1:0] i_flush_tid,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [TID_W-1:0] o_tid,
    output logic [6:0]       o_opcode,
    output logic [2:0]       o_funct3,
    output logic [6:0]       o_funct7,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_wa,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal
);

    // Format class codes as seen on o_fmt.
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // One fully decoded pipeline entry.
    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       wa;
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
    } entry_t;

    // Format class from the full 7-bit opcode; anything not listed, including
    // every opcode whose low two bits are not 2'b11, is unsupported.
    function automatic logic [2:0] decode_fmt(input logic [6:0] opcode);
        logic [2:0] fmt;
        case (opcode)
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:                         fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110011:                                     fmt = FMT_R;
            default:                                        fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // 32-bit immediate for the given format; R and unsupported give zero.
    function automatic logic [31:0] extract_imm(input logic [31:0] instr,
                                                input logic [2:0]  fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'h000};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    // Widen a 32-bit immediate to XLEN, replicating bit 31.
    function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] imm32);
        logic signed [31:0] simm;
        simm = imm32;
        return XLEN'(simm);
    endfunction

    // Full decode of one instruction into a storable entry.
    function automatic entry_t decode_instr(input logic [31:0]      instr,
                                            input logic [TID_W-1:0] tid);
        entry_t e;
        logic [2:0] fmt;
        fmt       = decode_fmt(instr[6:0]);
        e.tid     = tid;
        e.opcode  = instr[6:0];
        e.funct3  = instr[14:12];
        e.funct7  = instr[31:25];
        e.rs1     = instr[19:15];
        e.rs2     = instr[24:20];
        e.wa      = instr[11:7];
        e.imm     = sext_xlen(extract_imm(instr, fmt));
        e.fmt     = fmt;
        e.illegal = (fmt == FMT_NONE);
        return e;
    endfunction

    // Contents presented on the data outputs while the stage is in reset.
    function automatic entry_t reset_entry();
        entry_t e;
        e     = '0;
        e.fmt = FMT_NONE;
        return e;
    endfunction

    entry_t or_data_r;
    entry_t sk_data_r;
    logic   or_valid_r;
    logic   sk_valid_r;
    logic   ready_r;

    entry_t in_dec_s;
    entry_t or_data_s;
    entry_t sk_data_s;
    logic   or_valid_s;
    logic   sk_valid_s;
    logic   accept_s;
    logic   in_keep_s;
    logic   sk_keep_s;
    logic   or_hold_s;

    // Next-state of OR/SK: drain/refill OR from SK then input, else park input in SK.
    always_comb begin
        in_dec_s   = decode_instr(i_instruction, i_tid);
        accept_s   = i_valid && ready_r;
        // A flushed input still completes its handshake but is not stored.
        in_keep_s  = accept_s && !(i_flush && (i_tid == i_flush_tid));
        sk_keep_s  = sk_valid_r && !(i_flush && (sk_data_r.tid == i_flush_tid));
        // OR stays put only if it is valid, not delivered and not flushed;
        // a delivered entry ignores a same-cycle flush of its thread.
        or_hold_s  = or_valid_r && !i_ready
                     && !(i_flush && (or_data_r.tid == i_flush_tid));
        or_valid_s = or_valid_r;
        or_data_s  = or_data_r;
        sk_valid_s = sk_valid_r;
        sk_data_s  = sk_data_r;
        if (or_hold_s) begin
            or_valid_s = 1'b1;
            // Accept implies SK was empty, so the input never overwrites SK.
            if (in_keep_s) begin
                sk_valid_s = 1'b1;
                sk_data_s  = in_dec_s;
            end else begin
                sk_valid_s = sk_keep_s;
            end
        end else begin
            sk_valid_s = 1'b0;
            if (sk_keep_s) begin
                or_valid_s = 1'b1;
                or_data_s  = sk_data_r;
            end else if (in_keep_s) begin
                or_valid_s = 1'b1;
                or_data_s  = in_dec_s;
            end else begin
                or_valid_s = 1'b0;
            end
        end
    end

    // Storage registers and the registered ready (ready whenever SK will be empty).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            or_valid_r <= 1'b0;
            sk_valid_r <= 1'b0;
            ready_r    <= 1'b0;
            or_data_r  <= reset_entry();
            sk_data_r  <= reset_entry();
        end else begin
            or_valid_r <= or_valid_s;
            sk_valid_r <= sk_valid_s;
            ready_r    <= !sk_valid_s;
            or_data_r  <= or_data_s;
            sk_data_r  <= sk_data_s;
        end
    end

    assign o_ready   = ready_r;
    assign o_valid   = or_valid_r;
    assign o_tid     = or_data_r.tid;
    assign o_opcode  = or_data_r.opcode;
    assign o_funct3  = or_data_r.funct3;
    assign o_funct7  = or_data_r.funct7;
    assign o_rs1     = or_data_r.rs1;
    assign o_rs2     = or_data_r.rs2;
    assign o_wa      = or_data_r.wa;
    assign o_imm     = or_data_r.imm;
    assign o_fmt     = or_data_r.fmt;
    assign o_illegal = or_data_r.illegal;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Testbench for pipelined_instruction_decoder: directed scenarios followed by
// randomized traffic, all checked against a FIFO-level reference model.
module tb_pipelined_instruction_decoder;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instruction;
    logic [3:0]  i_tid;
    logic        i_flush;
    logic [3:0]  i_flush_tid;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_tid;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_wa;
    logic [31:0] o_imm;
    logic [2:0]  o_fmt;
    logic        o_illegal;

    int tests_run;
    int tests_failed;

    // Reference model: the stage behaves as an ordered queue of at most two
    // {tid, instruction} entries whose head is what the outputs show.
    logic [35:0] q[$];
    logic        rdy_m;
    logic        rst_m;

    pipelined_instruction_decoder dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instruction (i_instruction),
        .i_tid         (i_tid),
        .i_flush       (i_flush),
        .i_flush_tid   (i_flush_tid),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_tid         (o_tid),
        .o_opcode      (o_opcode),
        .o_funct3      (o_funct3),
        .o_funct7      (o_funct7),
        .o_rs1         (o_rs1),
        .o_rs2         (o_rs2),
        .o_wa          (o_wa),
        .o_imm         (o_imm),
        .o_fmt         (o_fmt),
        .o_illegal     (o_illegal)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected format class and immediate, computed from the RV32I rules.
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] fmt,
                                       output logic [31:0] imm);
        logic signed [31:0] si;
        logic signed [31:0] hi;
        logic [31:0]        sign;
        si   = ins;
        sign = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                fmt = 3'd4;
                imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                fmt = 3'd5;
                imm = (sign << 20) | (ins & 32'h000F_F000) | (((ins >> 20) & 32'h1) << 11)
                      | (((ins >> 21) & 32'h3FF) << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
                fmt = 3'd1;
                hi  = si >>> 20;
                imm = hi;
            end
            7'h23: begin
                fmt = 3'd2;
                hi  = si >>> 25;
                imm = (32'(hi) << 5) | ((ins >> 7) & 32'h1F);
            end
            7'h63: begin
                fmt = 3'd3;
                imm = (sign << 12) | (((ins >> 7) & 32'h1) << 11)
                      | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            end
            7'h33: begin
                fmt = 3'd0;
                imm = 32'h0;
            end
            default: begin
                fmt = 3'd7;
                imm = 32'h0;
            end
        endcase
    endfunction

    task automatic check_outputs();
        logic [35:0] e;
        logic [31:0] ins;
        logic [2:0]  fmt;
        logic [31:0] imm;
        check_val("o_valid", 64'(o_valid), 64'(q.size() > 0));
        check_val("o_ready", 64'(o_ready), 64'(rdy_m));
        if (rst_m) begin
            check_val("rst_tid", 64'(o_tid), 64'd0);
            check_val("rst_opcode", 64'(o_opcode), 64'd0);
            check_val("rst_funct3", 64'(o_funct3), 64'd0);
            check_val("rst_funct7", 64'(o_funct7), 64'd0);
            check_val("rst_rs1", 64'(o_rs1), 64'd0);
            check_val("rst_rs2", 64'(o_rs2), 64'd0);
            check_val("rst_wa", 64'(o_wa), 64'd0);
            check_val("rst_imm", 64'(o_imm), 64'd0);
            check_val("rst_fmt", 64'(o_fmt), 64'd7);
            check_val("rst_illegal", 64'(o_illegal), 64'd0);
        end else if (q.size() > 0) begin
            e   = q[0];
            ins = e[31:0];
            ref_decode(ins, fmt, imm);
            check_val("tid", 64'(o_tid), 64'(e[35:32]));
            check_val("opcode", 64'(o_opcode), 64'(ins & 32'h7F));
            check_val("funct3", 64'(o_funct3), 64'((ins >> 12) & 32'h7));
            check_val("funct7", 64'(o_funct7), 64'(ins >> 25));
            check_val("rs1", 64'(o_rs1), 64'((ins >> 15) & 32'h1F));
            check_val("rs2", 64'(o_rs2), 64'((ins >> 20) & 32'h1F));
            check_val("wa", 64'(o_wa), 64'((ins >> 7) & 32'h1F));
            check_val("imm", 64'(o_imm), 64'(imm));
            check_val("fmt", 64'(o_fmt), 64'(fmt));
            check_val("illegal", 64'(o_illegal), 64'(fmt == 3'd7));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then compare outputs on the following falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [3:0] t,
                        input logic rdy, input logic fl, input logic [3:0] ft,
                        input logic rs);
        logic        acc;
        logic [35:0] keep[$];
        logic [35:0] dropped;
        i_valid       = v;
        i_instruction = ins;
        i_tid         = t;
        i_ready       = rdy;
        i_flush       = fl;
        i_flush_tid   = ft;
        i_rst         = rs;
        if (rs) begin
            q.delete();
            rdy_m = 1'b0;
            rst_m = 1'b1;
        end else begin
            rst_m = 1'b0;
            acc   = v && rdy_m;
            if (rdy && q.size() > 0) begin
                dropped = q.pop_front();
            end
            if (fl) begin
                keep = {};
                foreach (q[k]) begin
                    if (q[k][35:32] != ft) keep.push_back(q[k]);
                end
                q = keep;
            end
            if (acc && !(fl && t == ft)) q.push_back({t, ins});
            rdy_m = (q.size() < 2);
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [6:0] pick_opcode(input int k);
        case (k)
            0:       return 7'h37;
            1:       return 7'h17;
            2:       return 7'h6F;
            3:       return 7'h67;
            4:       return 7'h03;
            5:       return 7'h13;
            6:       return 7'h0F;
            7:       return 7'h73;
            8:       return 7'h23;
            9:       return 7'h63;
            default: return 7'h33;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic [3:0]  t;
        logic [3:0]  ft;
        tests_run    = 0;
        tests_failed = 0;
        rdy_m        = 1'b0;
        rst_m        = 1'b0;

        // Reset, then the first instruction appears one cycle after acceptance.
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'hFFF0_0093, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("p1_valid", 64'(o_valid), 64'd1);
        check_val("p1_fmt", 64'(o_fmt), 64'd1);
        check_val("p1_wa", 64'(o_wa), 64'd1);
        check_val("p1_rs1", 64'(o_rs1), 64'd0);
        check_val("p1_imm", 64'(o_imm), 64'hFFFF_FFFF);
        check_val("p1_tid", 64'(o_tid), 64'd3);
        check_val("p1_illegal", 64'(o_illegal), 64'd0);

        // Back-to-back stream, including unsupported encodings.
        step(1'b1, 32'h0020_A423, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("s_fmt", 64'(o_fmt), 64'd2);
        check_val("s_imm", 64'(o_imm), 64'd8);
        check_val("s_rs1", 64'(o_rs1), 64'd1);
        check_val("s_rs2", 64'(o_rs2), 64'd2);
        step(1'b1, 32'hFE00_0EE3, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("b_fmt", 64'(o_fmt), 64'd3);
        check_val("b_imm", 64'(o_imm), 64'hFFFF_FFFC);
        step(1'b1, 32'h1234_52B7, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("u_fmt", 64'(o_fmt), 64'd4);
        check_val("u_imm", 64'(o_imm), 64'h1234_5000);
        check_val("u_wa", 64'(o_wa), 64'd5);
        step(1'b1, 32'h0000_0000, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("z_illegal", 64'(o_illegal), 64'd1);
        check_val("z_fmt", 64'(o_fmt), 64'd7);
        step(1'b1, 32'h0000_007F, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("x_illegal", 64'(o_illegal), 64'd1);
        check_val("x_imm", 64'(o_imm), 64'd0);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Backpressure: two stored, third refused until space frees up.
        step(1'b1, 32'h0050_0113, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'h0020_8033, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        check_val("bp_ready", 64'(o_ready), 64'd0);
        step(1'b1, 32'h4020_8033, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'h4020_8033, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("bp_second", 64'(o_tid), 64'd2);
        step(1'b1, 32'h4020_8033, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("bp_third", 64'(o_tid), 64'd3);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Flush of the OR thread while stalled: SK entry moves up.
        step(1'b1, 32'h0011_0113, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'h0022_0213, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
        check_val("fl_or_tid", 64'(o_tid), 64'd2);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        check_val("fl_valid", 64'(o_valid), 64'd1);
        check_val("fl_sk_tid", 64'(o_tid), 64'd5);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Flush coinciding with delivery: the tid-2 entry is still delivered.
        step(1'b1, 32'h0011_0113, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'h0022_0213, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
        check_val("fd_or_tid", 64'(o_tid), 64'd2);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0);
        check_val("fd_next_tid", 64'(o_tid), 64'd5);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset with both registers full, then decode resumes cleanly.
        step(1'b1, 32'h0011_0113, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'h0022_0213, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        check_val("mr_valid", 64'(o_valid), 64'd0);
        step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 32'hFFF0_0093, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0);
        check_val("mr_fmt", 64'(o_fmt), 64'd1);
        check_val("mr_imm", 64'(o_imm), 64'hFFFF_FFFF);
        check_val("mr_tid", 64'(o_tid), 64'd7);

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = pick_opcode($urandom_range(0, 10));
            t  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            ft = 4'($urandom_range(0, 3));
            step(1'($urandom_range(0, 9) < 7), ins, t, 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 9) == 0), ft, 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
Registered, flow-controlled RV32I decode stage for the barrel-threaded core. It accepts a fetched instruction tagged with its hardware-thread ID and splits it into register fields. It also produces the sign-extended immediate, the format class and an illegal-instruction flag, all with one cycle of latency. A two-entry skid buffer absorbs backpressure, and a per-thread flush discards in-flight entries of a redirected thread.

Parameters:
XLEN, 32, immediate output width (>=32); immediates sign-extended from bit 31.
NUM_THREADS, 16, number of hardware threads.
TID_W, $clog2(NUM_THREADS) (min 1), thread-ID width.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_valid  in  1  input instruction valid
o_ready  out  1  stage can accept input
i_instruction  in  32  instruction word
i_tid  in  TID_W  thread ID of input
i_flush  in  1  flush request
i_flush_tid  in  TID_W  thread to flush
o_valid  out  1  decoded entry valid
i_ready  in  1  downstream accepts entry
o_tid  out  TID_W  thread ID of entry
o_opcode  out  7  instr[6:0]
o_funct3  out  3  instr[14:12]
o_funct7  out  7  instr[31:25]
o_rs1  out  5  instr[19:15]
o_rs2  out  5  instr[24:20]
o_wa  out  5  instr[11:7]
o_imm  out  XLEN  immediate
o_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=none
o_illegal  out  1  unsupported encoding

Behaviour:
- Reset is synchronous and active-high on i_clk. While i_rst is high: o_valid=0, skid entry invalid, o_ready=0. All data outputs are 0 and o_fmt=7.
- Input transfers on i_valid&&o_ready; output transfers on o_valid&&i_ready.
- Storage is an output register (OR) and a skid register (SK). o_ready = !SK.valid, registered.
- Latency: an accepted instruction appears on outputs the next cycle when OR is empty or draining.
- Decode is computed combinationally on input and stored in decoded form. Outputs are driven from OR only; no comb path from input to output.
- Data movement each cycle:
  - OR drains or is empty: SK (if valid) moves to OR, else the accepted input moves to OR.
  - OR is held and input is accepted: the input goes to SK.
  - Order is strictly preserved.
- Formats by opcode:
  - 0110111 and 0010111 → U.
  - 1101111 → J.
  - 1100111, 0000011, 0010011, 0001111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110011 → R.
  - Any other opcode, or instr[1:0]!=2'b11 → fmt=7, illegal=1, imm=0.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25],instr[11:7]}).
  - B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U = {instr[31:12],12'b0} sext.
  - J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - R → imm=0.
- Field outputs are raw slices regardless of format, including for illegal instructions.
- Flush (i_flush=1): in the same cycle, OR and SK entries with tid==i_flush_tid are invalidated.
  - An input with matching tid accepted that cycle is consumed (handshake completes) but not stored.
  - Entries of other threads are unaffected.
- Flush + output transfer on the same OR entry: the transfer completes (entry delivered); flush has no further effect on it.
- Flush invalidates OR but SK is valid with another tid: SK moves to OR next cycle.
- Idle outputs: o_valid=0 leaves data outputs holding their last value; the bench must not check them.
- Throughput: 1 instruction/cycle while i_ready=1. Both OR and SK full and i_ready=0: o_ready=0, no state change.

Test Plan:
- Reset, then 0xFFF00093 tid 3 → next cycle: o_valid=1, fmt=1, o_wa=1, o_rs1=0, o_imm=0xFFFFFFFF, o_tid=3, illegal=0.
- Back-to-back stream:
  - 0x0020A423 → fmt=2, imm=8, rs1=1, rs2=2.
  - 0xFE000EE3 → fmt=3, imm=0xFFFFFFFC.
  - 0x123452B7 → fmt=4, imm=0x12345000, wa=5.
  - All delivered in order, one per cycle.
- 0x00000000 and 0x0000007F → illegal=1, fmt=7, imm=0.
- Hold i_ready=0 and offer 3 instructions → two stored, o_ready=0 after the second. Release → all three delivered in order with no loss or duplication.
- OR holds tid 2, SK holds tid 5, pulse i_flush with tid 2 while i_ready=0 → tid-2 entry vanishes, tid-5 entry appears next cycle. Repeat with i_ready=1 in the flush cycle → tid-2 entry is delivered.
- Assert i_rst mid-stream with OR and SK full → next cycle o_valid=0; after release the first new input decodes correctly.
